// File: rtl/fp_round_pipe.sv
// fp_round_pipe: two-stage IEEE rounder with RISC-V rounding modes, special values and fflags.
// Define FP_ROUND_SUBNORM_EN to denormalise tiny results instead of flushing them to zero.
module fp_round_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sign,
  input  logic [EXP_W+1:0]         in_exp,
  input  logic [MAN_W-1:0]         in_man,
  input  logic [2:0]               in_grs,
  input  logic [2:0]               in_rm,
  input  logic                     in_nan,
  input  logic                     in_nv,
  input  logic                     in_inf,
  input  logic                     in_zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_result,
  output logic [4:0]               out_flags
);
  localparam logic [2:0] RNE = 3'd0, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;
  localparam logic [2:0] C_NAN = 3'd0, C_INF = 3'd1, C_ZERO = 3'd2, C_FTZ = 3'd3, C_OVF = 3'd4, C_NORM = 3'd5;
  localparam logic [EXP_W-1:0] E_MAX = '1;
  localparam logic [EXP_W-1:0] E_MXF = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [EXP_W+1:0] E_OVF = {2'b00, E_MAX};
  localparam logic [MAN_W-1:0] M_ZERO = '0;
  localparam logic [MAN_W-1:0] M_ONES = '1;
  localparam logic [MAN_W-1:0] M_QNAN = {1'b1, {(MAN_W-1){1'b0}}};

  logic r1_valid, r2_valid, w_s1_adv, w_s2_adv;
  logic [2:0] r1_cls;
  logic r1_sign, r1_inc, r1_nx, r1_uf, r1_nv, r1_oinf;
  logic [EXP_W-1:0] r1_exp;
  logic [MAN_W-1:0] r1_man;
  logic [EXP_W+MAN_W:0] r2_result;
  logic [4:0] r2_flags;

  logic [MAN_W-1:0] w_man;
  logic [EXP_W-1:0] w_efld;
  logic [2:0] w_cls;
  logic w_g, w_r, w_s, w_nx, w_inc, w_tiny, w_ovf, w_bad_rm, w_nv, w_oinf, w_uf;

  assign w_s2_adv   = !r2_valid | out_ready;
  assign w_s1_adv   = !r1_valid | w_s2_adv;
  assign in_ready   = w_s1_adv;
  assign out_valid  = r2_valid;
  assign out_result = r2_result;
  assign out_flags  = r2_flags;

  assign w_tiny   = in_exp[EXP_W+1] | (in_exp == '0);
  assign w_ovf    = !in_exp[EXP_W+1] & (in_exp >= E_OVF);
  assign w_bad_rm = in_rm > RMM;
  assign w_nv     = in_nv | (!in_nan & w_bad_rm);
  assign w_oinf   = (in_rm == RNE) | (in_rm == RMM) | ((in_rm == RDN) & in_sign) | ((in_rm == RUP) & !in_sign);

`ifdef FP_ROUND_SUBNORM_EN
  localparam logic [2:0] C_TINY = C_NORM;
  localparam logic [EXP_W+2:0] SH_MAX = (EXP_W+3)'(MAN_W+2);
  logic [EXP_W+2:0] w_sh_raw, w_sh;
  logic [2*MAN_W+5:0] w_wide;
  assign w_sh_raw = (EXP_W+3)'(1) - {in_exp[EXP_W+1], in_exp};
  assign w_sh     = (w_sh_raw > SH_MAX) ? SH_MAX : w_sh_raw;
  assign w_wide   = {1'b1, in_man, in_grs[2:1], {(MAN_W+3){1'b0}}} >> w_sh;
  assign w_uf     = w_tiny & w_nx;
  // Tiny beats become subnormals: shifted significand, sticky collects every lost bit.
  always_comb begin
    w_man  = w_tiny ? w_wide[2*MAN_W+4:MAN_W+5] : in_man;
    w_g    = w_tiny ? w_wide[MAN_W+4] : in_grs[2];
    w_r    = w_tiny ? w_wide[MAN_W+3] : in_grs[1];
    w_s    = in_grs[0] | (w_tiny & (|w_wide[MAN_W+2:0]));
    w_efld = w_tiny ? '0 : in_exp[EXP_W-1:0];
  end
`else
  localparam logic [2:0] C_TINY = C_FTZ;
  assign w_uf = 1'b0;
  always_comb begin
    w_man  = in_man;
    w_g    = in_grs[2];
    w_r    = in_grs[1];
    w_s    = in_grs[0];
    w_efld = in_exp[EXP_W-1:0];
  end
`endif

  always_comb begin
    w_nx  = w_g | w_r | w_s;
    w_inc = (in_rm == RNE) ? w_g & (w_r | w_s | w_man[0]) :
            (in_rm == RDN) ? in_sign & w_nx :
            (in_rm == RUP) ? !in_sign & w_nx :
            (in_rm == RMM) ? w_g : 1'b0;
    w_cls = (in_nan | in_nv) ? C_NAN :
            in_inf           ? C_INF :
            in_zero          ? C_ZERO :
            w_bad_rm         ? C_NAN :
            w_ovf            ? C_OVF :
            w_tiny           ? C_TINY : C_NORM;
  end

  logic [MAN_W-1:0] w_msum;
  logic [EXP_W-1:0] w_esum;
  logic [EXP_W+MAN_W:0] w_res;
  logic [4:0] w_flags;
  logic w_carry, w_ovf2;

  // A rounding carry can push a finite beat into the overflow path.
  always_comb begin
    {w_carry, w_msum} = {1'b0, r1_man} + {{MAN_W{1'b0}}, r1_inc};
    w_esum  = r1_exp + {{(EXP_W-1){1'b0}}, w_carry};
    w_ovf2  = (r1_cls == C_OVF) | ((r1_cls == C_NORM) & (w_esum == E_MAX));
    w_res   = w_ovf2 ? (r1_oinf ? {r1_sign, E_MAX, M_ZERO} : {r1_sign, E_MXF, M_ONES}) :
              (r1_cls == C_NAN) ? {1'b0, E_MAX, M_QNAN} :
              (r1_cls == C_INF) ? {r1_sign, E_MAX, M_ZERO} :
              (r1_cls == C_NORM) ? {r1_sign, w_esum, w_msum} : {r1_sign, {EXP_W{1'b0}}, M_ZERO};
    w_flags = w_ovf2 ? 5'b00101 :
              (r1_cls == C_NAN) ? {r1_nv, 4'b0000} :
              (r1_cls == C_FTZ) ? 5'b00011 :
              (r1_cls == C_NORM) ? {3'b000, r1_uf, r1_nx} : 5'b00000;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r1_valid  <= 1'b0;
      r2_valid  <= 1'b0;
      r2_result <= '0;
      r2_flags  <= '0;
    end else begin
      if (w_s1_adv) r1_valid <= in_valid;
      if (w_s2_adv) r2_valid <= r1_valid;
      if (w_s2_adv & r1_valid) begin
        r2_result <= w_res;
        r2_flags  <= w_flags;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_s1_adv & in_valid) begin
      r1_cls  <= w_cls;
      r1_sign <= in_sign;
      r1_exp  <= w_efld;
      r1_man  <= w_man;
      r1_inc  <= w_inc;
      r1_nx   <= w_nx;
      r1_uf   <= w_uf;
      r1_nv   <= w_nv;
      r1_oinf <= w_oinf;
    end
  end
endmodule

// File: tb/tb_fp_round_pipe.sv
// tb_fp_round_pipe: directed and randomised checks of fp_round_pipe against an arithmetic reference model.
module tb_fp_round_pipe;
  logic clk = 0, reset_n = 0, in_valid = 0, in_sign = 0, out_ready = 1;
  logic in_nan = 0, in_nv = 0, in_inf = 0, in_zero = 0;
  logic [9:0] in_exp = '0;
  logic [22:0] in_man = '0;
  logic [2:0] in_grs = '0, in_rm = '0;
  logic in_ready, out_valid;
  logic [31:0] out_result;
  logic [4:0] out_flags;
  int n_chk = 0, n_fail = 0;
  logic [36:0] sb[$];

  typedef struct packed {
    logic s; logic [9:0] e; logic [22:0] m; logic [2:0] grs, rm;
    logic nan, nv, inf, zero; logic [31:0] res; logic [4:0] fl;
  } vec_t;
  vec_t vecs[$];

  fp_round_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man), .in_grs(in_grs), .in_rm(in_rm),
    .in_nan(in_nan), .in_nv(in_nv), .in_inf(in_inf), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: value-level rounding of 1.m * 2^e, returns {result, flags}.
  function automatic logic [36:0] model(input logic s, input int e, input logic [22:0] m,
                                        input logic [2:0] grs, input logic [2:0] rm,
                                        input logic nan, input logic nv, input logic inf, input logic zero);
    longint mant, sig, lost;
    int ef, sh;
    logic g, r, st, nx, up, tiny, to_inf;
    if (nan || nv) return {32'h7FC00000, nv, 4'b0000};
    if (inf) return {s, 8'hFF, 23'd0, 5'd0};
    if (zero) return {s, 31'd0, 5'd0};
    if (rm > 3'd4) return {32'h7FC00000, 5'b10000};
    to_inf = (rm == 0) || (rm == 4) || (rm == 2 && s) || (rm == 3 && !s);
    mant = longint'(m); g = grs[2]; r = grs[1]; st = grs[0]; ef = e; tiny = 0;
    if (e <= 0) begin
`ifdef FP_ROUND_SUBNORM_EN
      sh = (1 - e > 25) ? 25 : 1 - e;
      sig = (longint'(1) << 25) | (longint'(m) << 2) | (longint'(g) << 1) | longint'(r);
      lost = sig & ((longint'(1) << sh) - 1);
      sig = sig >> sh;
      mant = sig >> 2; g = sig[1]; r = sig[0]; st = st | (lost != 0); ef = 0; tiny = 1;
`else
      return {s, 31'd0, 5'b00011};
`endif
    end
    nx = g | r | st;
    case (rm)
      3'd0: up = g && (r || st || mant[0]);
      3'd1: up = 0;
      3'd2: up = s && nx;
      3'd3: up = !s && nx;
      default: up = g;
    endcase
    mant = mant + longint'(up);
    if (mant == (longint'(1) << 23)) begin mant = 0; ef++; end
    if (ef >= 255) return {s, to_inf ? 8'hFF : 8'hFE, to_inf ? 23'd0 : 23'h7FFFFF, 5'b00101};
    return {s, ef[7:0], mant[22:0], 3'b000, tiny && nx, nx};
  endfunction

  function automatic vec_t mk(input logic s, input int e, input logic [22:0] m, input logic [2:0] grs,
                              input logic [2:0] rm, input logic [31:0] res, input logic [4:0] fl);
    vec_t v;
    v = '0;
    v.s = s; v.e = 10'(e); v.m = m; v.grs = grs; v.rm = rm; v.res = res; v.fl = fl;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    in_sign = v.s; in_exp = v.e; in_man = v.m; in_grs = v.grs; in_rm = v.rm;
    in_nan = v.nan; in_nv = v.nv; in_inf = v.inf; in_zero = v.zero;
  endtask

  task automatic send(input vec_t v);
    int n;
    apply(v);
    in_valid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin @(negedge clk); n++; end
    check(name, 64'(sb.size()), 0);
  endtask

  always @(negedge clk) if (reset_n) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL spurious_out: got result %h with no beat pending", out_result);
      end else begin
        check("result", {out_result, out_flags}, sb[0]);
        if (out_ready) void'(sb.pop_front());
      end
    end
    if (in_valid && in_ready)
      sb.push_back(model(in_sign, int'($signed(in_exp)), in_man, in_grs, in_rm, in_nan, in_nv, in_inf, in_zero));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int e;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_flags", out_flags, 0);
    reset_n = 1;
    #1 check("rst_in_ready", in_ready, 1);

    vecs.push_back(mk(0, 127, 23'h000001, 3'b100, 3'd0, 32'h3F800002, 5'b00001));
    vecs.push_back(mk(0, 127, 23'h000000, 3'b100, 3'd0, 32'h3F800000, 5'b00001));
    vecs.push_back(mk(0, 127, 23'h7FFFFF, 3'b110, 3'd0, 32'h40000000, 5'b00001));
    vecs.push_back(mk(0, 255, 23'h000000, 3'b100, 3'd0, 32'h7F800000, 5'b00101));
    vecs.push_back(mk(0, 255, 23'h000000, 3'b100, 3'd1, 32'h7F7FFFFF, 5'b00101));
    vecs.push_back(mk(1, 255, 23'h000000, 3'b100, 3'd3, 32'hFF7FFFFF, 5'b00101));
    vecs.push_back(mk(0, 254, 23'h7FFFFF, 3'b100, 3'd0, 32'h7F800000, 5'b00101));
`ifdef FP_ROUND_SUBNORM_EN
    vecs.push_back(mk(0, 0, 23'h400000, 3'b000, 3'd0, 32'h00600000, 5'b00000));
    vecs.push_back(mk(1, -3, 23'h000000, 3'b000, 3'd0, 32'h80080000, 5'b00000));
`else
    vecs.push_back(mk(0, 0, 23'h400000, 3'b000, 3'd0, 32'h00000000, 5'b00011));
    vecs.push_back(mk(1, -3, 23'h000000, 3'b000, 3'd0, 32'h80000000, 5'b00011));
`endif
    v = mk(0, 127, 23'h0, 3'b000, 3'd0, 32'h7FC00000, 5'b10000); v.nan = 1; v.nv = 1; vecs.push_back(v);
    v = mk(0, 127, 23'h0, 3'b000, 3'd0, 32'h7FC00000, 5'b00000); v.nan = 1; vecs.push_back(v);
    vecs.push_back(mk(0, 127, 23'h000000, 3'b000, 3'd5, 32'h7FC00000, 5'b10000));
    v = mk(1, 127, 23'h0, 3'b111, 3'd0, 32'hFF800000, 5'b00000); v.inf = 1; vecs.push_back(v);
    v = mk(1, 127, 23'h0, 3'b111, 3'd0, 32'h80000000, 5'b00000); v.zero = 1; vecs.push_back(v);
    vecs.push_back(mk(1, 127, 23'h000000, 3'b001, 3'd2, 32'hBF800001, 5'b00001));
    vecs.push_back(mk(0, 130, 23'h000005, 3'b100, 3'd4, 32'h41000006, 5'b00001));
    vecs.push_back(mk(0, 1, 23'h000000, 3'b000, 3'd0, 32'h00800000, 5'b00000));

    foreach (vecs[i])
      check($sformatf("model_v%0d", i),
            model(vecs[i].s, int'($signed(vecs[i].e)), vecs[i].m, vecs[i].grs, vecs[i].rm,
                  vecs[i].nan, vecs[i].nv, vecs[i].inf, vecs[i].zero), {vecs[i].res, vecs[i].fl});

    foreach (vecs[i]) send(vecs[i]);
    in_valid = 0;
    drain("drain_directed");

    @(posedge clk); #1;
    apply(vecs[0]);
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk) check("lat_cycle1", out_valid, 0);
    @(negedge clk) check("lat_cycle2", out_valid, 1);
    drain("drain_latency");

    @(posedge clk); #1;
    out_ready = 0;
    send(vecs[1]);
    send(vecs[2]);
    apply(vecs[3]);
    @(negedge clk) check("bp_in_ready_low", in_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) check("bp_in_ready_still_low", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1;
    @(negedge clk) check("bp_out0", out_valid, 1);
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk) check("bp_out1", out_valid, 1);
    @(negedge clk) check("bp_out2", out_valid, 1);
    @(negedge clk) check("bp_done", out_valid, 0);
    drain("drain_bp");

    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      e = int'($urandom_range(0, 300)) - 25;
      in_sign = 1'($urandom); in_exp = 10'(e); in_man = 23'($urandom);
      in_grs = 3'($urandom); in_rm = 3'($urandom_range(0, 7));
      in_nan = ($urandom_range(0, 15) == 0); in_nv = ($urandom_range(0, 15) == 0);
      in_inf = ($urandom_range(0, 15) == 0); in_zero = ($urandom_range(0, 15) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 0;
    out_ready = 1;
    drain("drain_random");

    @(posedge clk); #1;
    out_ready = 0;
    send(vecs[0]);
    send(vecs[1]);
    in_valid = 0;
    @(negedge clk) check("rst_pre_valid", out_valid, 1);
    #2 reset_n = 0;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_result", out_result, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 reset_n = 1;
    out_ready = 1;
    #1 check("rst_rel_in_ready", in_ready, 1);
    repeat (5) @(negedge clk) check("rst_no_emit", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
